// File: rtl/sram_bank_if.sv
// sram_bank_if: request/response bundle between the load/store control
// (master) and the sram_bank (slave).
interface sram_bank_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              en;
   logic              rd;
   logic              wt;
   logic [ADDR_W-1:0] add;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              err;
   logic              busy;

   modport master (
      output en, rd, wt, add, din,
      input  dout, dout_valid, err, busy
   );

   modport slave (
      input  en, rd, wt, add, din,
      output dout, dout_valid, err, busy
   );
endinterface

// File: rtl/sram_bank.sv
// sram_bank: parametrised single-port synchronous SRAM bank with an
// RD_LAT-deep read pipeline, one-cycle error strobe for illegal requests and
// an optional post-reset clear sequencer enabled by SRAM_INIT_CLEAR_EN.
module sram_bank #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   sram_bank_if.slave  bus
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [RD_LAT-1:0] vld_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];
   logic              err_q;
   logic              err_d;
   logic              busy;
   logic              in_range;
   logic              rd_acc;
   logic              wr_acc;
   logic [IDX_W-1:0]  idx;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_wa;
   logic [DATA_W-1:0] mem_wd;

   assign in_range = ({1'b0, bus.add} < (ADDR_W+1)'(DEPTH));
   assign idx      = bus.add[IDX_W-1:0];

   // Classify the request sampled at this edge.
   always_comb begin
      rd_acc = 1'b0;
      wr_acc = 1'b0;
      err_d  = 1'b0;
      if (bus.en && (bus.rd || bus.wt)) begin
         if (busy || (bus.rd && bus.wt) || !in_range) begin
            err_d = 1'b1;
         end else begin
            rd_acc = bus.rd;
            wr_acc = bus.wt;
         end
      end
   end

`ifdef SRAM_INIT_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_READY} clr_state_e;

   clr_state_e       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             clr_we;

   // Clear sequencer state; reset restarts the sweep from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sweep one word per cycle, leave CLEAR after the last word is written.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign busy   = (state_q == ST_CLEAR);
   assign mem_we = clr_we | wr_acc;
   assign mem_wa = clr_we ? cnt_q : idx;
   assign mem_wd = clr_we ? '0 : bus.din;
`else
   assign busy   = 1'b0;
   assign mem_we = wr_acc;
   assign mem_wa = idx;
   assign mem_wd = bus.din;
`endif

   // Storage array; deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   // Read pipeline: stage 0 captures memory at the request edge, the last
   // stage is dout and only moves when a valid word arrives, so it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         err_q <= 1'b0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         err_q    <= err_d;
         vld_q[0] <= rd_acc;
         if (rd_acc) begin
            dat_q[0] <= mem_q[idx];
         end
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign bus.dout       = dat_q[RD_LAT-1];
   assign bus.dout_valid = vld_q[RD_LAT-1];
   assign bus.err        = err_q;
   assign bus.busy       = busy;
endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: randomized scoreboard bench for sram_bank (DEPTH=8, RD_LAT=3).
// Works with or without SRAM_INIT_CLEAR_EN defined.
module tb_sram_bank;
   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 4;
   localparam int unsigned DEP = 8;
   localparam int unsigned LAT = 3;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   exp_t          rq[$];
   bit            exp_err[int];
   logic [DW-1:0] model[DEP];
   logic [DW-1:0] last_dout = '0;

   sram_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

   sram_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Drive one request for the next edge and record what it must produce.
   task automatic issue(input bit e, input bit r, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k;
      @(negedge clk);
      bus.en = e; bus.rd = r; bus.wt = w; bus.add = a; bus.din = d;
      k = cyc + 1;
      if (e && (r || w)) begin
         if ((r && w) || (int'(a) >= DEP)) exp_err[k] = 1'b1;
         else if (w) model[a[2:0]] = d;
         else rq.push_back('{model[a[2:0]], k + LAT - 1});
      end
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Release reset; with the clear sequencer, also measure busy and try a
   // write while busy (it must be rejected and dropped).
   task automatic release_reset();
      int n;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef SRAM_INIT_CLEAR_EN
      for (int i = 0; i < DEP; i++) model[i] = '0;
      bus.en = 1'b1; bus.wt = 1'b1; bus.rd = 1'b0; bus.add = 4'd1; bus.din = 8'h77;
      exp_err[cyc + 1] = 1'b1;
      n = 0;
      while (1) begin
         @(posedge clk); #1;
         if (n == 0) begin bus.en = 1'b0; bus.wt = 1'b0; end
         n++;
         if (!bus.busy || n > 4 * DEP) break;
      end
      chk("busy_len", 64'(n), 64'(DEP));
`else
      n = 0;
      chk("busy_after_release", {63'b0, bus.busy}, 64'd0);
`endif
   endtask

   // Monitor: compares every cycle against the scoreboard.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            chk("rst_dout", 64'(bus.dout), 64'd0);
            chk("rst_valid", {63'b0, bus.dout_valid}, 64'd0);
            chk("rst_err", {63'b0, bus.err}, 64'd0);
            last_dout = '0;
         end else begin
            chk("err", {63'b0, bus.err},
                {63'b0, exp_err.exists(cyc) ? exp_err[cyc] : 1'b0});
`ifndef SRAM_INIT_CLEAR_EN
            chk("busy", {63'b0, bus.busy}, 64'd0);
`endif
            if (rq.size() > 0 && rq[0].due < cyc) begin
               checks++; errors++;
               $display("FAIL missing_valid at edge %0d: got none expected data %0h due %0d",
                        cyc, rq[0].data, rq[0].due);
               void'(rq.pop_front());
            end
            if (bus.dout_valid) begin
               if (rq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_valid at edge %0d: got %0h expected no strobe",
                           cyc, bus.dout);
                  last_dout = bus.dout;
               end else begin
                  chk("valid_edge", 64'(cyc), 64'(rq[0].due));
                  chk("rdata", 64'(bus.dout), 64'(rq[0].data));
                  last_dout = rq[0].data;
                  void'(rq.pop_front());
               end
            end else begin
               chk("dout_hold", 64'(bus.dout), 64'(last_dout));
            end
         end
      end
   end

   // Stimulus.
   initial begin
      bus.en = 1'b0; bus.rd = 1'b0; bus.wt = 1'b0; bus.add = '0; bus.din = '0;
      repeat (3) @(negedge clk);
      chk("init_dout", 64'(bus.dout), 64'd0);
      chk("init_valid", {63'b0, bus.dout_valid}, 64'd0);
      chk("init_err", {63'b0, bus.err}, 64'd0);
`ifdef SRAM_INIT_CLEAR_EN
      chk("init_busy", {63'b0, bus.busy}, 64'd1);
`else
      chk("init_busy", {63'b0, bus.busy}, 64'd0);
`endif
      release_reset();
`ifdef SRAM_INIT_CLEAR_EN
      for (int i = 0; i < DEP; i++) issue(1'b1, 1'b1, 1'b0, AW'(i), '0);
`endif
      // Fill every word so later reads are defined.
      for (int i = 0; i < DEP; i++) issue(1'b1, 1'b0, 1'b1, AW'(i), DW'(8'h30 + i * 7));

      // Directed cases.
      issue(1'b1, 1'b0, 1'b1, 4'd3, 8'hA5);
      issue(1'b1, 1'b1, 1'b0, 4'd3, '0);
      issue(1'b1, 1'b0, 1'b1, 4'd0, 8'h11);
      issue(1'b1, 1'b0, 1'b1, 4'd1, 8'h22);
      issue(1'b1, 1'b0, 1'b1, 4'd2, 8'h33);
      for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, 1'b0, AW'(i), '0);
      issue(1'b1, 1'b1, 1'b1, 4'd2, 8'hEE);
      issue(1'b1, 1'b0, 1'b1, 4'd9, 8'hDD);
      issue(1'b1, 1'b1, 1'b0, 4'd2, '0);
      issue(1'b1, 1'b1, 1'b0, 4'd15, '0);
      issue(1'b1, 1'b0, 1'b1, 4'd5, 8'h5A);
      issue(1'b1, 1'b1, 1'b0, 4'd5, '0);
      issue(1'b1, 1'b0, 1'b1, 4'd5, 8'hFF);
      issue(1'b1, 1'b1, 1'b0, 4'd5, '0);
      issue(1'b0, 1'b1, 1'b0, 4'd5, '0);
      repeat (LAT + 1) idle();

      // Reset with a read in flight: no strobe may appear for it.
      issue(1'b1, 1'b1, 1'b0, 4'd4, '0);
      idle();
      @(negedge clk);
      bus.en = 1'b0; bus.rd = 1'b0; bus.wt = 1'b0;
      rst_n = 1'b0;
      rq.delete();
      #1;
      chk("async_rst_dout", 64'(bus.dout), 64'd0);
      chk("async_rst_valid", {63'b0, bus.dout_valid}, 64'd0);
      repeat (2) @(negedge clk);
      release_reset();
      for (int i = 0; i < DEP; i++) issue(1'b1, 1'b1, 1'b0, AW'(i), '0);

      // Randomized traffic over legal and illegal addresses.
      for (int i = 0; i < 400; i++) begin
         issue($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
               AW'($urandom_range(0, 15)), DW'($urandom));
      end

      repeat (LAT + 3) idle();
      checks++;
      if (rq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding reads expected 0", rq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
